// File: rtl/kuz_stream_adapter.sv
// ---------------------------------------------------------------------------
// kuz_stream_adapter
//
// Byte-stream front/back end for the Kuznechik encryption core. Sits between
// a byte-wide host link and the core:
//   - assembles a 256-bit key from 32 input bytes, then 128-bit plaintext
//     blocks from 16 input bytes each (MSB-first packing),
//   - drives the core's read_key / read_word / input_key / input_word
//     handshake,
//   - captures output_word on core write and serialises the ciphertext out
//     as 16 bytes, MSB-first.
//
// Ports
//   i_clk, i_rst_n          clock (posedge), asynchronous active-low reset
//   i_in_data/i_in_valid    input byte stream (key bytes, then block bytes)
//   o_in_ready              byte accepted when i_in_valid & o_in_ready
//   i_rekey_req             level; high at result capture ends the session
//   o_out_data/o_out_valid  ciphertext byte stream
//   i_out_ready             byte taken when o_out_valid & i_out_ready
//   o_core_read_key         core read_key
//   o_core_read_word        core read_word
//   o_core_input_key        core input_key (256 bits)
//   o_core_input_word       core input_word (128 bits)
//   i_core_output_word      core output_word (128 bits)
//   i_core_write            core write (result valid)
//   i_core_ready            core ready (1 = busy)
// ---------------------------------------------------------------------------
module kuz_stream_adapter #(
    parameter int KEY_BYTES = 32,
    parameter int BLK_BYTES = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_in_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic                   i_rekey_req,
    output logic [7:0]             o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_core_read_key,
    output logic                   o_core_read_word,
    output logic [8*KEY_BYTES-1:0] o_core_input_key,
    output logic [8*BLK_BYTES-1:0] o_core_input_word,
    input  logic [8*BLK_BYTES-1:0] i_core_output_word,
    input  logic                   i_core_write,
    input  logic                   i_core_ready
);

    localparam int         KEY_W    = 8 * KEY_BYTES;
    localparam int         BLK_W    = 8 * BLK_BYTES;
    localparam logic [4:0] KEY_LAST = 5'(KEY_BYTES - 1);
    localparam logic [4:0] BLK_LAST = 5'(BLK_BYTES - 1);

    typedef enum logic [2:0] {
        S_KEY_FILL  = 3'd0,
        S_KEY_RUN   = 3'd1,
        S_WORD_FILL = 3'd2,
        S_WORD_RUN  = 3'd3,
        S_WR_LOW    = 3'd4,
        S_OUT       = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [4:0]       r_cnt;
    logic [KEY_W-1:0] r_key;
    logic [BLK_W-1:0] r_word;
    logic [BLK_W-1:0] r_cap;
    logic             r_busy_seen;
    logic             r_read_key;
    logic             r_read_word;
    logic             r_end;

    logic w_in_rdy;
    logic w_in_xfer;
    logic w_out_vld;
    logic w_out_xfer;
    logic w_key_done;
    logic w_blk_done;
    logic w_out_done;
    logic w_sched_done;
    logic w_capture;

    // Input is only taken while filling; everywhere else in_valid just stalls.
    assign w_in_rdy   = (r_state == S_KEY_FILL) || (r_state == S_WORD_FILL);
    assign w_in_xfer  = i_in_valid && w_in_rdy;
    assign w_out_vld  = (r_state == S_OUT);
    assign w_out_xfer = w_out_vld && i_out_ready;

    assign w_key_done   = (r_state == S_KEY_FILL)  && w_in_xfer  && (r_cnt == KEY_LAST);
    assign w_blk_done   = (r_state == S_WORD_FILL) && w_in_xfer  && (r_cnt == BLK_LAST);
    assign w_out_done   = (r_state == S_OUT)       && w_out_xfer && (r_cnt == BLK_LAST);
    // Key schedule is finished once the core has been seen busy and then idle.
    assign w_sched_done = (r_state == S_KEY_RUN)   && r_busy_seen && !i_core_ready;
    assign w_capture    = (r_state == S_WORD_RUN)  && i_core_write;

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_KEY_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_KEY_FILL:  if (w_key_done)    w_state_nxt = S_KEY_RUN;
            S_KEY_RUN:   if (w_sched_done)  w_state_nxt = S_WORD_FILL;
            S_WORD_FILL: if (w_blk_done)    w_state_nxt = S_WORD_RUN;
            S_WORD_RUN:  if (i_core_write)  w_state_nxt = S_WR_LOW;
            // Core drops write once it has seen read_word low.
            S_WR_LOW:    if (!i_core_write) w_state_nxt = S_OUT;
            S_OUT: begin
                if (w_out_done) begin
                    w_state_nxt = r_end ? S_KEY_FILL : S_WORD_FILL;
                end
            end
            default:                        w_state_nxt = S_KEY_FILL;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt       <= '0;
            r_key       <= '0;
            r_word      <= '0;
            r_cap       <= '0;
            r_busy_seen <= 1'b0;
            r_read_key  <= 1'b0;
            r_read_word <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            // Byte counter restarts on every state entry; it counts input
            // bytes in the fill states and output bytes in OUT.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_in_xfer || w_out_xfer) begin
                r_cnt <= r_cnt + 5'd1;
            end

            // MSB-first packing: after N shifts the first byte sits at the top.
            if ((r_state == S_KEY_FILL) && w_in_xfer) begin
                r_key <= {r_key[KEY_W-9:0], i_in_data};
            end
            if ((r_state == S_WORD_FILL) && w_in_xfer) begin
                r_word <= {r_word[BLK_W-9:0], i_in_data};
            end

            if (w_key_done) begin
                r_busy_seen <= 1'b0;
            end else if ((r_state == S_KEY_RUN) && i_core_ready) begin
                r_busy_seen <= 1'b1;
            end

            // On a rekey capture read_key falls together with read_word so
            // the core heads back to its key-load state.
            if (w_key_done) begin
                r_read_key <= 1'b1;
            end else if (w_capture && i_rekey_req) begin
                r_read_key <= 1'b0;
            end

            if (w_blk_done) begin
                r_read_word <= 1'b1;
            end else if (w_capture) begin
                r_read_word <= 1'b0;
            end

            if (w_capture) begin
                r_end <= i_rekey_req;
            end

            // Capture register doubles as the output shifter; the top byte is
            // always the one on offer, so it only moves after a transfer.
            if (w_capture) begin
                r_cap <= i_core_output_word;
            end else if (w_out_xfer) begin
                r_cap <= {r_cap[BLK_W-9:0], 8'h00};
            end
        end
    end

    assign o_in_ready        = w_in_rdy;
    assign o_out_valid       = w_out_vld;
    assign o_out_data        = r_cap[BLK_W-1 -: 8];
    assign o_core_read_key   = r_read_key;
    assign o_core_read_word  = r_read_word;
    assign o_core_input_key  = r_key;
    assign o_core_input_word = r_word;

endmodule
